tile_frame_scheduler: RTL and testbench
=======================================

// Module: tile_frame_scheduler
// PURPOSE
//  Sequences one tile_painter instance across the full frame, tile by tile, row-major.
//  Per tile: wipe the tile BRAM, paint all triangles, stream tile BRAM to the framebuffer.
//  Sits between the frame controller (frame_start/frame_done) and painter + framebuffer write port.
// PARAMETERS
//  MAX_TRIANGLES 256  triangle BRAM depth; sets num_triangles width
//  SCREEN_W      320  frame width in pixels (multiple of TILE_W)
//  SCREEN_H      180  frame height in pixels (multiple of TILE_H)
//  TILE_W        20   tile width in pixels
//  TILE_H        45   tile height in pixels
// PORTS
//  clk                 in   1   system clock
//  rst                 in   1   synchronous, active-high reset
//  frame_start         in   1   one-cycle pulse; begin a frame (honoured only in IDLE)
//  num_triangles_in    in   $clog2(MAX_TRIANGLES)  triangle count, latched on accepted frame_start
//  painter_done        in   1   painter done output
//  tile_bram_read_data in   32  tile BRAM read data, 2 cycles after tile_bram_read_addr
//  painter_active      out  1   painter active
//  painter_wipe        out  1   painter wipe
//  num_triangles       out  $clog2(MAX_TRIANGLES)  latched count to painter
//  x_offset            out  9   current tile left x
//  y_offset            out  8   current tile top y
//  copy_sel            out  1   high: top level gives tile BRAM read port to this block
//  tile_bram_read_addr out  10  copy read address, ty*TILE_W+tx
//  fb_write_addr       out  17  framebuffer address, (y_offset+ty)*SCREEN_W+x_offset+tx
//  fb_write_data       out  32  tile_bram_read_data passed through
//  fb_write_valid      out  1   framebuffer write strobe
//  busy                out  1   high in every state except IDLE
//  frame_done          out  1   one-cycle pulse after last tile copied
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; offsets 0; counters 0. rst mid-frame aborts at once, no frame_done.
//  States and transitions:
//   IDLE: on frame_start latch num_triangles, offsets=(0,0) -> WIPE.
//   WIPE: active=1, wipe=1; on painter_done -> GAP_A.
//   GAP_A: active=0, wipe=0 for 2 cycles (painter returns to RST, done clears) -> PAINT.
//   PAINT: active=1, wipe=0; on painter_done -> GAP_B.
//   GAP_B: active=0 for 2 cycles -> COPY.
//   COPY: copy_sel=1; tx 0..TILE_W-1 inner, ty 0..TILE_H-1 outer, one address per cycle (900 cycles).
//     After last address -> DRAIN.
//   DRAIN: copy_sel=1 for 2 cycles so the last reads land -> NEXT.
//   NEXT: x_offset+=TILE_W; at SCREEN_W wrap to 0, y_offset+=TILE_H; at SCREEN_H -> FDONE, else -> WIPE.
//   FDONE: frame_done=1 for one cycle -> IDLE.
//  Copy pipeline: tx/ty and valid delayed 2 stages to match BRAM latency;
//   fb_write_valid high exactly TILE_W*TILE_H cycles per tile, never during WIPE/PAINT/GAP.
//  painter_done is sampled only in WIPE/PAINT; a stale done in GAP states is ignored.
//  No timeout: WIPE/PAINT wait for painter_done indefinitely.
//  frame_start outside IDLE is ignored; num_triangles_in changes mid-frame have no effect.
//  num_triangles=0 still runs wipe and copy (tile written as all 32'hFFFFFFFF).
//  Address math unsigned, full width: 17 bits covers 320*180=57600.
// TESTING
//  Reset: hold rst 3 cycles -> all outputs 0, busy=0; frame_start during rst ignored.
//  Full frame, painter model returns done 5 cycles after active: 64 tiles, offsets (0,0),(20,0)..(300,0),(0,45)..(300,135); one frame_done.
//  Copy of tile (20,45): read addr 0 -> fb_write_addr 14420; addr 899 -> 28519; 900 valid writes, data matches.
//  Painter done delayed 1000 cycles in PAINT -> active held high, no fb writes, continues after done.
//  frame_start pulsed mid-frame -> ignored; exactly one frame_done; latched num_triangles unchanged.
//  rst asserted in COPY of tile 10 -> next cycle IDLE, fb_write_valid=0, no frame_done; new frame starts at (0,0).

Source files
------------

// File: rtl/tile_frame_scheduler.sv
// Walks one tile painter across the frame in row-major tile order: wipe, paint, then
// stream the tile BRAM into the framebuffer with a 2-cycle read-latency-matched pipeline.
module tile_frame_scheduler #(
   parameter int MAX_TRIANGLES = 256,
   parameter int SCREEN_W      = 320,
   parameter int SCREEN_H      = 180,
   parameter int TILE_W        = 20,
   parameter int TILE_H        = 45
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             frame_start,
   input  logic [$clog2(MAX_TRIANGLES)-1:0] num_triangles_in,
   input  logic                             painter_done,
   input  logic [31:0]                      tile_bram_read_data,
   output logic                             painter_active,
   output logic                             painter_wipe,
   output logic [$clog2(MAX_TRIANGLES)-1:0] num_triangles,
   output logic [8:0]                       x_offset,
   output logic [7:0]                       y_offset,
   output logic                             copy_sel,
   output logic [9:0]                       tile_bram_read_addr,
   output logic [16:0]                      fb_write_addr,
   output logic [31:0]                      fb_write_data,
   output logic                             fb_write_valid,
   output logic                             busy,
   output logic                             frame_done
);

   localparam int TXW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int TYW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int NTW = $clog2(MAX_TRIANGLES);
   localparam logic [8:0] X_LAST = 9'(SCREEN_W - TILE_W);
   localparam logic [7:0] Y_LAST = 8'(SCREEN_H - TILE_H);

   typedef enum logic [3:0] {
      S_IDLE, S_WIPE, S_GAP_A, S_PAINT, S_GAP_B, S_COPY, S_DRAIN, S_NEXT, S_FDONE
   } state_t;

   state_t           state_q, state_d;
   logic             gap_q;
   logic [TXW-1:0]   tx_q;
   logic [TYW-1:0]   ty_q;
   logic [8:0]       x_off_q;
   logic [7:0]       y_off_q;
   logic [NTW-1:0]   ntri_q;
   logic             vld_p1_q, vld_p2_q;
   logic [16:0]      addr_p1_q, addr_p2_q;

   logic             tx_last, ty_last, last_col, last_row;
   logic [9:0]       rd_addr_p0;
   logic [16:0]      fb_addr_p0;

   assign tx_last    = (tx_q == TXW'(TILE_W - 1));
   assign ty_last    = (ty_q == TYW'(TILE_H - 1));
   assign last_col   = (x_off_q == X_LAST);
   assign last_row   = (y_off_q == Y_LAST);
   assign rd_addr_p0 = 10'(32'(ty_q) * TILE_W + 32'(tx_q));
   assign fb_addr_p0 = 17'((32'(y_off_q) + 32'(ty_q)) * SCREEN_W + 32'(x_off_q) + 32'(tx_q));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (frame_start)       state_d = S_WIPE;
         S_WIPE:  if (painter_done)      state_d = S_GAP_A;
         S_GAP_A: if (gap_q)             state_d = S_PAINT;
         S_PAINT: if (painter_done)      state_d = S_GAP_B;
         S_GAP_B: if (gap_q)             state_d = S_COPY;
         S_COPY:  if (tx_last && ty_last) state_d = S_DRAIN;
         S_DRAIN: if (gap_q)             state_d = S_NEXT;
         S_NEXT:  state_d = (last_col && last_row) ? S_FDONE : S_WIPE;
         S_FDONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      painter_active      = (state_q == S_WIPE) || (state_q == S_PAINT);
      painter_wipe        = (state_q == S_WIPE);
      copy_sel            = (state_q == S_COPY) || (state_q == S_DRAIN);
      busy                = (state_q != S_IDLE);
      frame_done          = (state_q == S_FDONE);
      tile_bram_read_addr = (state_q == S_COPY) ? rd_addr_p0 : 10'd0;
      num_triangles       = ntri_q;
      x_offset            = x_off_q;
      y_offset            = y_off_q;
      fb_write_valid      = vld_p2_q;
      fb_write_addr       = vld_p2_q ? addr_p2_q : 17'd0;
      fb_write_data       = vld_p2_q ? tile_bram_read_data : 32'd0;
   end

   // Sequencing counters: gap_q times the 2-cycle GAP/DRAIN states, tx/ty walk the tile.
   always_ff @(posedge clk) begin
      if (rst) begin
         gap_q   <= 1'b0;
         tx_q    <= '0;
         ty_q    <= '0;
         x_off_q <= '0;
         y_off_q <= '0;
         ntri_q  <= '0;
      end else begin
         if (state_q == S_GAP_A || state_q == S_GAP_B || state_q == S_DRAIN)
            gap_q <= ~gap_q;
         else
            gap_q <= 1'b0;

         if (state_q == S_COPY) begin
            if (tx_last) begin
               tx_q <= '0;
               ty_q <= ty_last ? '0 : ty_q + 1'b1;
            end else begin
               tx_q <= tx_q + 1'b1;
            end
         end else begin
            tx_q <= '0;
            ty_q <= '0;
         end

         if (state_q == S_IDLE && frame_start) begin
            ntri_q  <= num_triangles_in;
            x_off_q <= '0;
            y_off_q <= '0;
         end else if (state_q == S_NEXT) begin
            if (last_col) begin
               x_off_q <= '0;
               y_off_q <= last_row ? 8'd0 : y_off_q + 8'(TILE_H);
            end else begin
               x_off_q <= x_off_q + 9'(TILE_W);
            end
         end
      end
   end

   // Stage p0 -> p1 -> p2: address and valid follow the BRAM read by its 2-cycle latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
      end else begin
         vld_p1_q <= (state_q == S_COPY);
         vld_p2_q <= vld_p1_q;
      end
   end

   always_ff @(posedge clk) begin
      addr_p1_q <= fb_addr_p0;
      addr_p2_q <= addr_p1_q;
   end

endmodule

// File: tb/tb_tile_frame_scheduler.sv
// Scoreboard bench for tile_frame_scheduler with painter and 2-cycle tile BRAM models.
module tb_tile_frame_scheduler;

   logic        clk;
   logic        rst;
   logic        frame_start;
   logic [7:0]  num_triangles_in;
   logic        painter_done;
   logic [31:0] tile_bram_read_data;
   logic        painter_active, painter_wipe, copy_sel, fb_write_valid, busy, frame_done;
   logic [7:0]  num_triangles;
   logic [8:0]  x_offset;
   logic [7:0]  y_offset;
   logic [9:0]  tile_bram_read_addr;
   logic [16:0] fb_write_addr;
   logic [31:0] fb_write_data;

   tile_frame_scheduler dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .num_triangles_in(num_triangles_in),
      .painter_done(painter_done), .tile_bram_read_data(tile_bram_read_data),
      .painter_active(painter_active), .painter_wipe(painter_wipe),
      .num_triangles(num_triangles), .x_offset(x_offset), .y_offset(y_offset),
      .copy_sel(copy_sel), .tile_bram_read_addr(tile_bram_read_addr),
      .fb_write_addr(fb_write_addr), .fb_write_data(fb_write_data),
      .fb_write_valid(fb_write_valid), .busy(busy), .frame_done(frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [16:0] addr;
      logic [31:0] data;
      int          tile;
      int          idx;
   } wr_t;
   typedef struct {
      logic [8:0] x;
      logic [7:0] y;
   } off_t;

   wr_t  exp_wr[$];
   off_t exp_off[$];
   int   total = 0;
   int   bad = 0;
   int   fd_cnt = 0;
   int   wipe_starts = 0;
   int   viol = 0;
   logic hold_done = 1'b0;

   function automatic logic [31:0] tb_data(input int a);
      return 32'hA5000000 + 32'(a) * 32'h00001003;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   task automatic push_tile(input int t);
      int x, y;
      off_t o;
      wr_t  w;
      x = (t % 16) * 20;
      y = (t / 16) * 45;
      o.x = 9'(x);
      o.y = 8'(y);
      exp_off.push_back(o);
      for (int ty = 0; ty < 45; ty++) begin
         for (int tx = 0; tx < 20; tx++) begin
            w.addr = 17'((y + ty) * 320 + x + tx);
            w.data = tb_data(ty * 20 + tx);
            w.tile = t;
            w.idx  = ty * 20 + tx;
            exp_wr.push_back(w);
         end
      end
   endtask

   // Painter: done 5 cycles after active rises, held one cycle after active drops.
   initial begin
      int   cnt;
      logic stale;
      cnt = 0;
      stale = 1'b0;
      painter_done = 1'b0;
      forever begin
         @(negedge clk);
         if (painter_active) begin
            cnt++;
            if (cnt >= 5 && !(hold_done && !painter_wipe)) painter_done = 1'b1;
         end else begin
            cnt = 0;
            if (painter_done && !stale) stale = 1'b1;
            else begin
               painter_done = 1'b0;
               stale = 1'b0;
            end
         end
      end
   end

   // Tile BRAM: read data appears two cycles after the address.
   initial begin
      logic [9:0]  a_s;
      logic [31:0] p1;
      p1 = 32'd0;
      tile_bram_read_data = 32'd0;
      forever begin
         @(negedge clk);
         a_s = tile_bram_read_addr;
         @(posedge clk);
         tile_bram_read_data = p1;
         p1 = tb_data(int'(a_s));
      end
   end

   // Monitor: pops the scoreboard on every framebuffer write and every tile start.
   initial begin
      logic prev_wipe;
      wr_t  e;
      off_t o;
      prev_wipe = 1'b0;
      forever begin
         @(negedge clk);
         if (fb_write_valid) begin
            if (exp_wr.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write actual=%0d required=none", fb_write_addr);
            end else begin
               e = exp_wr.pop_front();
               check("fb_addr", 32'(fb_write_addr), 32'(e.addr));
               check("fb_data", fb_write_data, e.data);
               if (e.tile == 17 && e.idx == 0)   check("t17_first_addr", 32'(fb_write_addr), 32'd14420);
               if (e.tile == 17 && e.idx == 899) check("t17_last_addr", 32'(fb_write_addr), 32'd28519);
            end
            if (painter_active || !copy_sel) viol++;
         end
         if (painter_wipe && !prev_wipe) begin
            wipe_starts++;
            if (exp_off.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_tile actual=(%0d,%0d) required=none", x_offset, y_offset);
            end else begin
               o = exp_off.pop_front();
               check("x_offset", 32'(x_offset), 32'(o.x));
               check("y_offset", 32'(y_offset), 32'(o.y));
            end
         end
         prev_wipe = painter_wipe;
         if (frame_done) fd_cnt++;
      end
   end

   initial begin
      int n, base;
      rst = 1'b1;
      frame_start = 1'b1;
      num_triangles_in = 8'd3;

      // Reset with frame_start held: everything idle and zero.
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_active", 32'(painter_active), 32'd0);
      check("rst_wipe", 32'(painter_wipe), 32'd0);
      check("rst_copy_sel", 32'(copy_sel), 32'd0);
      check("rst_fb_valid", 32'(fb_write_valid), 32'd0);
      check("rst_fb_addr", 32'(fb_write_addr), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_ntri", 32'(num_triangles), 32'd0);
      check("rst_x", 32'(x_offset), 32'd0);
      check("rst_y", 32'(y_offset), 32'd0);
      rst = 1'b0;
      frame_start = 1'b0;
      @(negedge clk);
      check("post_rst_busy", 32'(busy), 32'd0);

      // Full frame with a stray frame_start and count change mid-frame.
      for (int t = 0; t < 64; t++) push_tile(t);
      num_triangles_in = 8'd7;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("start_busy", 32'(busy), 32'd1);
      check("start_wipe", 32'(painter_wipe), 32'd1);
      check("start_ntri", 32'(num_triangles), 32'd7);
      n = 0;
      while (wipe_starts < 4 && n < 5000) begin @(negedge clk); n++; end
      check("wait_tile3", 32'(wipe_starts >= 4), 32'd1);
      num_triangles_in = 8'd99;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      @(negedge clk);
      check("midframe_ntri", 32'(num_triangles), 32'd7);
      check("midframe_busy", 32'(busy), 32'd1);
      n = 0;
      while (fd_cnt < 1 && n < 62000) begin @(negedge clk); n++; end
      check("frame_done_seen", 32'(fd_cnt), 32'd1);
      @(negedge clk);
      check("frame_end_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      check("frame_done_once", 32'(fd_cnt), 32'd1);
      check("tile_count", 32'(wipe_starts), 32'd64);
      check("writes_left", 32'(exp_wr.size()), 32'd0);
      check("tiles_left", 32'(exp_off.size()), 32'd0);
      check("ntri_kept", 32'(num_triangles), 32'd7);

      // Second frame: long paint on tile 0, then reset during copy of tile 10.
      base = wipe_starts;
      for (int t = 0; t < 11; t++) push_tile(t);
      hold_done = 1'b1;
      num_triangles_in = 8'd0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("f2_ntri", 32'(num_triangles), 32'd0);
      n = 0;
      while (!(painter_active && !painter_wipe) && n < 100) begin @(negedge clk); n++; end
      check("wait_paint", 32'(painter_active && !painter_wipe), 32'd1);
      repeat (995) @(negedge clk);
      check("hold_active", 32'(painter_active), 32'd1);
      check("hold_wipe", 32'(painter_wipe), 32'd0);
      check("hold_no_write", 32'(fb_write_valid), 32'd0);
      check("hold_copy_sel", 32'(copy_sel), 32'd0);
      hold_done = 1'b0;
      n = 0;
      while (wipe_starts < base + 11 && n < 15000) begin @(negedge clk); n++; end
      check("wait_tile10", 32'(wipe_starts), 32'(base + 11));
      n = 0;
      while (!copy_sel && n < 100) begin @(negedge clk); n++; end
      check("wait_copy10", 32'(copy_sel), 32'd1);
      repeat (100) @(negedge clk);
      check("copy10_writing", 32'(fb_write_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_fb_valid", 32'(fb_write_valid), 32'd0);
      check("abort_copy_sel", 32'(copy_sel), 32'd0);
      check("abort_active", 32'(painter_active), 32'd0);
      rst = 1'b0;
      exp_wr.delete();
      exp_off.delete();
      repeat (20) @(negedge clk);
      check("abort_no_done", 32'(fd_cnt), 32'd1);
      check("abort_idle", 32'(busy), 32'd0);

      // New frame after abort restarts from tile (0,0).
      base = wipe_starts;
      push_tile(0);
      push_tile(1);
      num_triangles_in = 8'd5;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      check("f3_x", 32'(x_offset), 32'd0);
      check("f3_y", 32'(y_offset), 32'd0);
      check("f3_wipe", 32'(painter_wipe), 32'd1);
      n = 0;
      while (wipe_starts < base + 2 && n < 2000) begin @(negedge clk); n++; end
      check("f3_tile1_start", 32'(wipe_starts), 32'(base + 2));
      check("f3_tile0_written", 32'(exp_wr.size()), 32'd900);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_wr.delete();
      exp_off.delete();
      @(negedge clk);

      check("write_outside_copy", 32'(viol), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
